// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM FIFO request generator: default widths,
// burst lengths agreed with the controller, and the arbiter state encoding.
package sdram_pkg;

    localparam int SDRAM_ADDR_W   = 24;
    localparam int SDRAM_BURST_W  = 10;
    localparam int SDRAM_WR_BURST = 256;
    localparam int SDRAM_RD_BURST = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_BUSY,
        ST_RD_REQ,
        ST_RD_BUSY
    } fifo_state_e;

endpackage

// File: rtl/sdram_addr_gen.sv
// Wrapping burst pointer for one SDRAM port. A load that arrives while the port
// is busy is deferred to the completion edge so a burst in flight is never disturbed.
module sdram_addr_gen
    import sdram_pkg::*;
#(
    parameter int          ADDR_W   = SDRAM_ADDR_W,
    parameter int unsigned BURST    = 256,
    parameter int unsigned MIN_ADDR = 0,
    parameter int unsigned MAX_ADDR = 1_048_576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              active,
    input  logic              done,
    output logic [ADDR_W-1:0] addr
);

    localparam int AW  = ADDR_W;
    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] MIN_A   = AW'(MIN_ADDR);
    localparam logic [ADDR_W:0]   BURST_X = AW1'(BURST);
    localparam logic [ADDR_W:0]   MAX_X   = AW1'(MAX_ADDR);

    logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
    logic [ADDR_W:0]   sum;
    logic              pend_q, pend_d;

    always_comb begin
        // one extra bit so addr + BURST cannot overflow before the wrap test
        sum      = {1'b0, addr_q} + BURST_X;
        addr_nxt = (sum >= MAX_X) ? MIN_A : sum[ADDR_W-1:0];
        addr_d   = addr_q;
        pend_d   = pend_q;
        if (done) begin
            addr_d = (load || pend_q) ? MIN_A : addr_nxt;
            pend_d = 1'b0;
        end else if (load) begin
            if (active) pend_d = 1'b1;
            else        addr_d = MIN_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= MIN_A;
            pend_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            pend_q <= pend_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/sdram_fifo_ctrl.sv
// Issues fixed-length SDRAM write/read burst requests from FIFO fill levels,
// one request outstanding at a time, write taking priority over read.
module sdram_fifo_ctrl
    import sdram_pkg::*;
#(
    parameter int          ADDR_W   = SDRAM_ADDR_W,
    parameter int          BURST_W  = SDRAM_BURST_W,
    parameter int unsigned WR_BURST = SDRAM_WR_BURST,
    parameter int unsigned RD_BURST = SDRAM_RD_BURST,
    parameter int unsigned MIN_ADDR = 0,
    parameter int unsigned MAX_ADDR = 1_048_576
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sdram_init_done,
    input  logic [BURST_W:0]   wrf_usedw,
    input  logic [BURST_W:0]   rdf_usedw,
    input  logic               rd_en,
    input  logic               wr_load,
    input  logic               rd_load,
    output logic               sdram_wr_req,
    input  logic               sdram_wr_ack,
    output logic [ADDR_W-1:0]  sdram_wr_addr,
    output logic [BURST_W-1:0] sdram_wr_burst,
    output logic               sdram_rd_req,
    input  logic               sdram_rd_ack,
    output logic [ADDR_W-1:0]  sdram_rd_addr,
    output logic [BURST_W-1:0] sdram_rd_burst
);

    localparam int BW = BURST_W;
    localparam int CW = BURST_W + 1;
    localparam logic [BURST_W:0] WR_TH = CW'(WR_BURST);
    localparam logic [BURST_W:0] RD_TH = CW'(RD_BURST);

    fifo_state_e state_q, state_d;
    logic        wr_ack_q, rd_ack_q;
    logic        wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic        wr_done, rd_done, wr_active, rd_active;

    assign wr_done   = (state_q == ST_WR_BUSY) && wr_ack_q && !sdram_wr_ack;
    assign rd_done   = (state_q == ST_RD_BUSY) && rd_ack_q && !sdram_rd_ack;
    assign wr_active = (state_q == ST_WR_REQ) || (state_q == ST_WR_BUSY);
    assign rd_active = (state_q == ST_RD_REQ) || (state_q == ST_RD_BUSY);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sdram_init_done) begin
                    if (wrf_usedw >= WR_TH)             state_d = ST_WR_REQ;
                    else if (rd_en && rdf_usedw < RD_TH) state_d = ST_RD_REQ;
                end
            end
            ST_WR_REQ:  if (sdram_wr_ack) state_d = ST_WR_BUSY;
            ST_WR_BUSY: if (wr_done)      state_d = ST_IDLE;
            ST_RD_REQ:  if (sdram_rd_ack) state_d = ST_RD_BUSY;
            ST_RD_BUSY: if (rd_done)      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
        // requests are registered copies of the next state so they carry no decode glitches
        wr_req_d = (state_d == ST_WR_REQ);
        rd_req_d = (state_d == ST_RD_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= sdram_wr_ack;
            rd_ack_q <= sdram_rd_ack;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
        end
    end

    sdram_addr_gen #(
        .ADDR_W(ADDR_W), .BURST(WR_BURST), .MIN_ADDR(MIN_ADDR), .MAX_ADDR(MAX_ADDR)
    ) u_wr_addr (
        .clk(clk), .rst_n(rst_n), .load(wr_load), .active(wr_active),
        .done(wr_done), .addr(sdram_wr_addr)
    );

    sdram_addr_gen #(
        .ADDR_W(ADDR_W), .BURST(RD_BURST), .MIN_ADDR(MIN_ADDR), .MAX_ADDR(MAX_ADDR)
    ) u_rd_addr (
        .clk(clk), .rst_n(rst_n), .load(rd_load), .active(rd_active),
        .done(rd_done), .addr(sdram_rd_addr)
    );

    assign sdram_wr_req   = wr_req_q;
    assign sdram_rd_req   = rd_req_q;
    assign sdram_wr_burst = BW'(WR_BURST);
    assign sdram_rd_burst = BW'(RD_BURST);

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Bench for sdram_fifo_ctrl with a 1024-word region and 256-word bursts.
module tb_sdram_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic [10:0] wrf_usedw, rdf_usedw;
    logic        rd_en, wr_load, rd_load;
    logic        wr_req, wr_ack, rd_req, rd_ack;
    logic [23:0] wr_addr, rd_addr;
    logic [9:0]  wr_burst, rd_burst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_rd;
        logic [23:0] addr;
    } exp_t;

    typedef struct {
        bit          is_rd;
        int          len;
        logic [23:0] addr;
        logic [23:0] nxt;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];

    sdram_fifo_ctrl #(
        .ADDR_W(24), .BURST_W(10), .WR_BURST(256), .RD_BURST(256),
        .MIN_ADDR(0), .MAX_ADDR(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(init_done),
        .wrf_usedw(wrf_usedw), .rdf_usedw(rdf_usedw), .rd_en(rd_en),
        .wr_load(wr_load), .rd_load(rd_load),
        .sdram_wr_req(wr_req), .sdram_wr_ack(wr_ack),
        .sdram_wr_addr(wr_addr), .sdram_wr_burst(wr_burst),
        .sdram_rd_req(rd_req), .sdram_rd_ack(rd_ack),
        .sdram_rd_addr(rd_addr), .sdram_rd_burst(rd_burst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Waits for a request, compares it with the scoreboard head, then runs the ack handshake.
    task automatic serve(input int len, input bit load_mid, input bit load_end, input bit rst_mid);
        exp_t e;
        bit   seen;
        bit   is_rd;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            check("req_overlap", 32'(wr_req & rd_req), 32'd0);
            seen = wr_req | rd_req;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL req_timeout no request within 40 cycles");
            return;
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected wr_req=%0b rd_req=%0b", wr_req, rd_req);
            return;
        end
        e = exp_q.pop_front();
        is_rd = rd_req;
        check("req_port", 32'(is_rd), 32'(e.is_rd));
        check("req_addr", 32'(is_rd ? rd_addr : wr_addr), 32'(e.addr));
        if (is_rd) begin
            rd_ack = 1'b1;
            rd_en  = 1'b0;
        end else begin
            wr_ack    = 1'b1;
            wrf_usedw = 11'd0;
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) check("req_fall", 32'(wr_req | rd_req), 32'd0);
            if (rst_mid && i == 2) begin
                rst_n  = 1'b0;
                wr_ack = 1'b0;
                rd_ack = 1'b0;
                #1;
                return;
            end
            wr_load = load_mid && (i == 1);
            if (i == len / 2)
                check("addr_stable", 32'(is_rd ? rd_addr : wr_addr), 32'(e.addr));
        end
        wr_ack  = 1'b0;
        rd_ack  = 1'b0;
        wr_load = load_end;
        @(negedge clk);
        wr_load = 1'b0;
        check("idle_after_done", 32'(wr_req | rd_req), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 256, 24'd512, 24'd768};
        vecs[1] = '{1'b0, 8,   24'd768, 24'd0};
        vecs[2] = '{1'b0, 8,   24'd0,   24'd256};
        vecs[3] = '{1'b0, 8,   24'd256, 24'd512};
        vecs[4] = '{1'b1, 8,   24'd256, 24'd512};
        vecs[5] = '{1'b1, 8,   24'd512, 24'd768};
        vecs[6] = '{1'b1, 8,   24'd768, 24'd0};

        rst_n = 1'b0; init_done = 1'b0; wrf_usedw = 11'd300; rdf_usedw = 11'd600;
        rd_en = 1'b0; wr_load = 1'b0; rd_load = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("wr_burst", 32'(wr_burst), 32'd256);
        check("rd_burst", 32'(rd_burst), 32'd256);
        rst_n = 1'b1;

        // init gating: full write FIFO but controller not ready
        repeat (5) @(negedge clk);
        check("init_gate", 32'(wr_req), 32'd0);
        init_done = 1'b1;
        exp_q.push_back('{1'b0, 24'd0});
        @(negedge clk);
        check("init_req_1cyc", 32'(wr_req), 32'd1);
        serve(256, 1'b0, 1'b0, 1'b0);
        check("wr_addr_after_init", 32'(wr_addr), 32'd256);

        // write and read requested in the same cycle: write first
        wrf_usedw = 11'd256; rd_en = 1'b1; rdf_usedw = 11'd0;
        exp_q.push_back('{1'b0, 24'd256});
        exp_q.push_back('{1'b1, 24'd0});
        @(negedge clk);
        check("prio_wr_req", 32'(wr_req), 32'd1);
        check("prio_rd_req", 32'(rd_req), 32'd0);
        serve(8, 1'b0, 1'b0, 1'b0);
        check("prio_wr_next", 32'(wr_addr), 32'd512);
        serve(8, 1'b0, 1'b0, 1'b0);
        check("prio_rd_next", 32'(rd_addr), 32'd256);

        for (int k = 0; k < 7; k++) begin
            if (vecs[k].is_rd) begin
                rd_en = 1'b1; rdf_usedw = 11'd0;
            end else begin
                wrf_usedw = 11'd256;
            end
            exp_q.push_back('{vecs[k].is_rd, vecs[k].addr});
            serve(vecs[k].len, 1'b0, 1'b0, 1'b0);
            check("vec_next_addr", 32'(vecs[k].is_rd ? rd_addr : wr_addr), 32'(vecs[k].nxt));
        end

        // load during WR_BUSY at 512: deferred, next pointer is 0 not 768
        wrf_usedw = 11'd256;
        exp_q.push_back('{1'b0, 24'd512});
        serve(8, 1'b1, 1'b0, 1'b0);
        check("load_busy_addr", 32'(wr_addr), 32'd0);
        wrf_usedw = 11'd256;
        exp_q.push_back('{1'b0, 24'd0});
        serve(8, 1'b0, 1'b0, 1'b0);
        check("after_load_burst", 32'(wr_addr), 32'd256);

        // load in IDLE takes effect on the next edge
        @(negedge clk);
        wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0;
        check("load_idle_addr", 32'(wr_addr), 32'd0);

        // load coincident with completion
        wrf_usedw = 11'd256;
        exp_q.push_back('{1'b0, 24'd0});
        serve(8, 1'b0, 1'b1, 1'b0);
        check("load_at_done", 32'(wr_addr), 32'd0);
        wrf_usedw = 11'd256;
        exp_q.push_back('{1'b0, 24'd0});
        serve(8, 1'b0, 1'b0, 1'b0);
        check("wr_addr_pre_rst", 32'(wr_addr), 32'd256);

        // reset during RD_BUSY
        rd_en = 1'b1; rdf_usedw = 11'd0;
        exp_q.push_back('{1'b1, 24'd0});
        serve(8, 1'b0, 1'b0, 1'b0);
        check("rd_addr_pre_rst", 32'(rd_addr), 32'd256);
        rd_en = 1'b1;
        exp_q.push_back('{1'b1, 24'd256});
        serve(8, 1'b0, 1'b0, 1'b1);
        check("rst_mid_rd_req", 32'(rd_req), 32'd0);
        check("rst_mid_wr_req", 32'(wr_req), 32'd0);
        check("rst_mid_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_en = 1'b1;
        exp_q.push_back('{1'b1, 24'd0});
        serve(8, 1'b0, 1'b0, 1'b0);
        check("rd_after_rst", 32'(rd_addr), 32'd256);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
